// File: rtl/mano_seq_ctrl_if.sv
// Handshake and status bundle between the Mano sequencer and the rest of the CPU.
// The sequencer takes the slave side; the IR/execute/memory environment takes the master side.
interface mano_seq_ctrl_if #(
    parameter int SC_W = 4
);
    logic                   start;
    logic [2:0]             ir_op;
    logic                   ir_i;
    logic                   mem_ready;
    logic                   sc_clr;
    logic                   hlt;
    logic                   int_req;
    logic [SC_W-1:0]        sc;
    logic [(1<<SC_W)-1:0]   t;
    logic [7:0]             d;
    logic                   i_ff;
    logic                   r_ff;
    logic                   mem_rd;
    logic                   mem_wr;
    logic                   busy;
    logic                   sc_err;

    modport slave (
        input  start, ir_op, ir_i, mem_ready, sc_clr, hlt, int_req,
        output sc, t, d, i_ff, r_ff, mem_rd, mem_wr, busy, sc_err
    );

    modport master (
        output start, ir_op, ir_i, mem_ready, sc_clr, hlt, int_req,
        input  sc, t, d, i_ff, r_ff, mem_rd, mem_wr, busy, sc_err
    );
endinterface

// File: rtl/mano_seq_ctrl.sv
// Mano basic-computer instruction-cycle sequencer: SC, one-hot T, latched D/I, fetch/indirect/interrupt handshakes.
// Define MANO_INTERRUPT_EN to build the interrupt cycle (R flip-flop, INTR state, mem_wr at RT1).
module mano_seq_ctrl #(
    parameter int SC_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mano_seq_ctrl_if.slave bus
);
    localparam int              T_W    = 1 << SC_W;
    localparam logic [1:0]      S_IDLE = 2'd0;
    localparam logic [1:0]      S_RUN  = 2'd1;
    localparam logic [1:0]      S_INTR = 2'd2;
    localparam logic [1:0]      S_HALT = 2'd3;
    localparam logic [SC_W-1:0] SC_MAX = '1;

    logic [1:0]      r_state;
    logic [SC_W-1:0] r_sc;
    logic [7:0]      r_d;
    logic            r_i_ff;
    logic            r_sc_err;
    logic            w_run;
    logic            w_intr;
    logic            w_rd;
    logic            w_wr;
    logic            w_stall;
    logic            w_r_ff;
    logic [T_W-1:0]  w_t;

    assign w_run  = (r_state == S_RUN);
    assign w_intr = (r_state == S_INTR);
    // T1 is always an IR fetch; T3 reads the effective address only for memory-reference indirect ops.
    assign w_rd   = w_run && ((r_sc == SC_W'(1)) ||
                              ((r_sc == SC_W'(3)) && !r_d[7] && r_i_ff));

`ifdef MANO_INTERRUPT_EN
    logic r_r_ff;
    assign w_r_ff = r_r_ff;
    assign w_wr   = w_intr && (r_sc == SC_W'(1));
`else
    logic w_unused;
    assign w_unused = bus.int_req;
    assign w_r_ff   = 1'b0;
    assign w_wr     = 1'b0;
`endif

    assign w_stall = (w_rd | w_wr) & ~bus.mem_ready;

    always_comb begin
        w_t = '0;
        if (w_run || w_intr) w_t[r_sc] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sc     <= '0;
            r_d      <= '0;
            r_i_ff   <= 1'b0;
            r_sc_err <= 1'b0;
`ifdef MANO_INTERRUPT_EN
            r_r_ff   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_sc    <= '0;
                    end
                end
                S_RUN: begin
                    if (r_sc == SC_W'(2)) begin
                        r_d    <= 8'(1) << bus.ir_op;
                        r_i_ff <= bus.ir_i;
                    end
                    if (bus.hlt) begin
                        r_state <= S_HALT;
                        r_sc    <= '0;
                    end
`ifdef MANO_INTERRUPT_EN
                    else if ((r_sc == '0) && bus.int_req && !r_r_ff) begin
                        r_r_ff  <= 1'b1;
                        r_state <= S_INTR;
                        r_sc    <= '0;
                    end
`endif
                    else if (bus.sc_clr) begin
                        r_sc <= '0;
                    end else if (!w_stall) begin
                        r_sc <= r_sc + 1'b1;
                        if (r_sc == SC_MAX) r_sc_err <= 1'b1;
                    end
                end
`ifdef MANO_INTERRUPT_EN
                // RT0..RT2 run to completion; hlt and sc_clr cannot cut the return-address save short.
                S_INTR: begin
                    if (r_sc == SC_W'(2)) begin
                        r_r_ff  <= 1'b0;
                        r_state <= S_RUN;
                        r_sc    <= '0;
                    end else if (!w_stall) begin
                        r_sc <= r_sc + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_sc    <= '0;
                end
            endcase
        end
    end

    assign bus.sc     = r_sc;
    assign bus.t      = w_t;
    assign bus.d      = r_d;
    assign bus.i_ff   = r_i_ff;
    assign bus.r_ff   = w_r_ff;
    assign bus.mem_rd = w_rd;
    assign bus.mem_wr = w_wr;
    assign bus.busy   = w_run | w_intr;
    assign bus.sc_err = r_sc_err;
endmodule

// File: tb/tb_mano_seq_ctrl.sv
// Scoreboard bench for mano_seq_ctrl: the stimulus queues hand-computed expectations per cycle,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_mano_seq_ctrl;
    logic clk;
    logic rst_n;

    mano_seq_ctrl_if #(.SC_W(4)) bus ();

    mano_seq_ctrl #(.SC_W(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [3:0]  sc;
        logic [15:0] t;
        logic [7:0]  d;
        logic        i_ff;
        logic        r_ff;
        logic        rd;
        logic        wr;
        logic        busy;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Queue this cycle's expectation, then advance to just after the next rising edge.
    task automatic cyc(input string nm, input logic [3:0] sc, input logic [15:0] t,
                       input logic [7:0] d, input logic i_ff, input logic r_ff,
                       input logic rd, input logic wr, input logic busy, input logic err);
        exp_t e;
        e.nm = nm; e.sc = sc; e.t = t; e.d = d; e.i_ff = i_ff; e.r_ff = r_ff;
        e.rd = rd; e.wr = wr; e.busy = busy; e.err = err;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            logic [34:0] act, req;
            e   = q.pop_front();
            act = {bus.sc, bus.t, bus.d, bus.i_ff, bus.r_ff, bus.mem_rd, bus.mem_wr, bus.busy, bus.sc_err};
            req = {e.sc, e.t, e.d, e.i_ff, e.r_ff, e.rd, e.wr, e.busy, e.err};
            n_chk++;
            if (act === req) n_pass++;
            else $display("FAIL %s: got sc=%0d t=%h d=%h i=%b r=%b rd=%b wr=%b busy=%b err=%b, want sc=%0d t=%h d=%h i=%b r=%b rd=%b wr=%b busy=%b err=%b",
                          e.nm, bus.sc, bus.t, bus.d, bus.i_ff, bus.r_ff, bus.mem_rd, bus.mem_wr, bus.busy, bus.sc_err,
                          e.sc, e.t, e.d, e.i_ff, e.r_ff, e.rd, e.wr, e.busy, e.err);
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 0; bus.ir_op = 0; bus.ir_i = 0; bus.mem_ready = 0;
        bus.sc_clr = 0; bus.hlt = 0; bus.int_req = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("reset_idle", 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0);

        // Plain fetch of op 010, direct.
        bus.start = 1; bus.ir_op = 3'b010; bus.ir_i = 0; bus.mem_ready = 1;
        cyc("idle_start", 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0);
        bus.start = 0;
        cyc("a_T0", 0, 16'h0001, 8'h00, 0, 0, 0, 0, 1, 0);
        cyc("a_T1", 1, 16'h0002, 8'h00, 0, 0, 1, 0, 1, 0);
        cyc("a_T2", 2, 16'h0004, 8'h00, 0, 0, 0, 0, 1, 0);
        cyc("a_T3", 3, 16'h0008, 8'h04, 0, 0, 0, 0, 1, 0);
        cyc("a_T4", 4, 16'h0010, 8'h04, 0, 0, 0, 0, 1, 0);
        bus.sc_clr = 1;
        cyc("a_T5_clr", 5, 16'h0020, 8'h04, 0, 0, 0, 0, 1, 0);
        bus.sc_clr = 0;

        // Op 000 indirect: extra read at T3 stalled two cycles.
        bus.ir_op = 3'b000; bus.ir_i = 1;
        cyc("b_T0", 0, 16'h0001, 8'h04, 0, 0, 0, 0, 1, 0);
        cyc("b_T1", 1, 16'h0002, 8'h04, 0, 0, 1, 0, 1, 0);
        cyc("b_T2", 2, 16'h0004, 8'h04, 0, 0, 0, 0, 1, 0);
        bus.mem_ready = 0;
        cyc("b_T3_stall1", 3, 16'h0008, 8'h01, 1, 0, 1, 0, 1, 0);
        cyc("b_T3_stall2", 3, 16'h0008, 8'h01, 1, 0, 1, 0, 1, 0);
        bus.mem_ready = 1;
        cyc("b_T3_go", 3, 16'h0008, 8'h01, 1, 0, 1, 0, 1, 0);
        cyc("b_T4", 4, 16'h0010, 8'h01, 1, 0, 0, 0, 1, 0);
        bus.hlt = 1; bus.sc_clr = 1;
        cyc("b_T5_hlt_clr", 5, 16'h0020, 8'h01, 1, 0, 0, 0, 1, 0);
        bus.hlt = 0; bus.sc_clr = 0;
        cyc("halted", 0, 16'h0000, 8'h01, 1, 0, 0, 0, 0, 0);

        // Op 111 (register/IO) with I=1: no T3 read; run to SC wrap.
        bus.start = 1; bus.ir_op = 3'b111; bus.ir_i = 1; bus.mem_ready = 0;
        cyc("halt_start", 0, 16'h0000, 8'h01, 1, 0, 0, 0, 0, 0);
        bus.start = 0;
        cyc("c_T0_noreq", 0, 16'h0001, 8'h01, 1, 0, 0, 0, 1, 0);
        cyc("c_T1_stall", 1, 16'h0002, 8'h01, 1, 0, 1, 0, 1, 0);
        bus.mem_ready = 1;
        cyc("c_T1_go", 1, 16'h0002, 8'h01, 1, 0, 1, 0, 1, 0);
        cyc("c_T2", 2, 16'h0004, 8'h01, 1, 0, 0, 0, 1, 0);
        cyc("c_T3", 3, 16'h0008, 8'h80, 1, 0, 0, 0, 1, 0);
        for (int k = 4; k < 16; k++)
            cyc($sformatf("c_T%0d", k), 4'(k), 16'(1) << k, 8'h80, 1, 0, 0, 0, 1, 0);
        cyc("c_wrap_T0", 0, 16'h0001, 8'h80, 1, 0, 0, 0, 1, 1);
        cyc("c_T1_err", 1, 16'h0002, 8'h80, 1, 0, 1, 0, 1, 1);
        bus.sc_clr = 1;
        cyc("c_T2_clr", 2, 16'h0004, 8'h80, 1, 0, 0, 0, 1, 1);
        bus.sc_clr = 0;

        // Interrupt request at T0.
        bus.int_req = 1;
`ifdef MANO_INTERRUPT_EN
        cyc("i_T0_req", 0, 16'h0001, 8'h80, 1, 0, 0, 0, 1, 1);
        bus.int_req = 0;
        cyc("i_RT0", 0, 16'h0001, 8'h80, 1, 1, 0, 0, 1, 1);
        bus.mem_ready = 0;
        cyc("i_RT1_stall", 1, 16'h0002, 8'h80, 1, 1, 0, 1, 1, 1);
        bus.mem_ready = 1;
        cyc("i_RT1", 1, 16'h0002, 8'h80, 1, 1, 0, 1, 1, 1);
        cyc("i_RT2", 2, 16'h0004, 8'h80, 1, 1, 0, 0, 1, 1);
        cyc("i_T0_after", 0, 16'h0001, 8'h80, 1, 0, 0, 0, 1, 1);
        cyc("i_T1_after", 1, 16'h0002, 8'h80, 1, 0, 1, 0, 1, 1);
`else
        cyc("i_T0_ignored", 0, 16'h0001, 8'h80, 1, 0, 0, 0, 1, 1);
        bus.int_req = 0;
        cyc("i_T1_fetch", 1, 16'h0002, 8'h80, 1, 0, 1, 0, 1, 1);
`endif

        // Asynchronous reset while T1 is stalled.
        bus.sc_clr = 1;
        cyc("r_T2_clr", 2, 16'h0004, 8'h80, 1, 0, 0, 0, 1, 1);
        bus.sc_clr = 0;
        cyc("r_T0", 0, 16'h0001, 8'h80, 1, 0, 0, 0, 1, 1);
        bus.mem_ready = 0;
        cyc("r_T1_stall", 1, 16'h0002, 8'h80, 1, 0, 1, 0, 1, 1);
        rst_n = 1'b0;
        cyc("async_reset", 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc("post_reset", 0, 16'h0000, 8'h00, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mano_seq_ctrl.md
# mano_seq_ctrl

Instruction-cycle sequencer for the Mano basic computer. It owns the 4-bit sequence counter (SC) and emits the one-hot timing signals T0–T15. It latches the decoded opcode lines D0–D7 and the indirect bit I, and issues the fetch/indirect/interrupt memory handshakes. The execute-phase control logic and the register/bus datapath consume its outputs; it sits between the IR and the control-word generator.

## Interface
Parameters:
- SC_W, 4, sequence-counter width (T output width is 2**SC_W)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  leave IDLE/HALT and begin at T0
- ir_op  in  3  IR[14:12] opcode field
- ir_i  in  1  IR[15] indirect bit
- mem_ready  in  1  memory access completes this cycle
- sc_clr  in  1  end-of-instruction clear from execute logic
- hlt  in  1  HLT instruction executing
- int_req  in  1  IEN & (FGI | FGO), pre-combined
- sc  out  4  current SC value
- t  out  16  one-hot timing, t[k] = T(k)
- d  out  8  one-hot latched opcode, d[n] = Dn (op 000 → d[0])
- i_ff  out  1  latched indirect bit
- r_ff  out  1  interrupt-cycle flip-flop
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- busy  out  1  state is RUN or INTR
- sc_err  out  1  sticky: SC wrapped without sc_clr

## Operation
- States: IDLE (reset), RUN, INTR, HALT.
- IDLE/HALT: sc=0, t=0, no memory requests. start=1 → RUN at the next edge with sc=0.
- RUN, per SC: T0 fetch address; T1 mem_rd=1 (IR←M[AR]); T2 latch d ← one-hot(ir_op) and i_ff ← ir_i; T3 mem_rd=1 only if d[7]=0 and i_ff=1 (indirect AR←M[AR]); T3+ execute.
- SC update priority, highest first: hlt → HALT with sc←0; sc_clr → sc←0; stall (mem_rd|mem_wr)&!mem_ready → hold; otherwise sc←sc+1.
- SC wrap from 15 to 0 without sc_clr sets sc_err; it is cleared only by reset.
- d and i_ff hold their values until the next T2 latch. Reset clears them.
- t = one-hot(sc) in RUN/INTR, all-zero otherwise.

## Timing
- Reset values: state=IDLE, sc=0, t=0, d=0, i_ff=0, r_ff=0, mem_rd=0, mem_wr=0, busy=0, sc_err=0.
- t, mem_rd, mem_wr and busy are combinational from registered state and sc. All other outputs are registered.
- d and i_ff become valid the cycle after T2, i.e. at T3.
- Minimum fetch with mem_ready held high: T0–T2 take 3 cycles. Each cycle of mem_ready=0 during T1 adds one cycle.
- mem_ready is ignored when no request is active.
- hlt and sc_clr in the same cycle: hlt wins.
- sc_clr during a stall: the clear wins and the request drops.
- Reset mid-instruction: asynchronous return to IDLE; any in-flight request is abandoned.

## Configuration
- MANO_INTERRUPT_EN defined:
  - In RUN at sc=0, with int_req=1 and r_ff=0, r_ff is set at the next edge and the state moves to INTR with sc=0. That instruction's fetch does not start.
  - INTR sequence: RT0 (AR←0, TR←PC); RT1 mem_wr=1, stalls on mem_ready; RT2 clears r_ff, then RUN with sc=0.
  - hlt is ignored in INTR.
- MANO_INTERRUPT_EN undefined: INTR is unreachable, r_ff is constant 0, int_req is ignored, and mem_wr is constant 0.

## Test plan
- Reset then start, ir_op=3'b010, ir_i=0, mem_ready=1: t walks 0x0001→0x0002→0x0004→0x0008. d=8'h04 from T3. No mem_rd at T3.
- ir_op=3'b000, ir_i=1: mem_rd=1 at T1 and T3, and d=8'h01. Hold mem_ready=0 for 2 cycles at T3: sc stays 3 for exactly 2 extra cycles.
- sc_clr at T5: sc=0 and t=0x0001 next cycle. Assert hlt and sc_clr together: state=HALT, busy=0, t=0.
- Never assert sc_clr: after 16 cycles sc wraps to 0 and sc_err=1, which stays set until rst_n=0.
- MANO_INTERRUPT_EN defined, int_req=1 at T0: r_ff=1, mem_wr=1 at RT1, r_ff=0 after RT2, then a fetch at T0. With the macro undefined, the same stimulus produces a normal fetch.
- Pull rst_n low at T1 during a stall: all outputs return to their reset values immediately, without waiting for a clock edge.
